// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//
// Read-side engine for a synchronous FIFO with a 1-cycle registered read port.
// It issues pops, absorbs the read latency, and re-presents the words as a
// valid/ready stream at a sustained rate of one word per clock, in FIFO order.
//
// Ports
//   clk        in   1       system clock, all state on the rising edge
//   rst_n      in   1       asynchronous active-low reset (shared with FIFO)
//   buf_out    in   DATA_W  FIFO read data, valid the cycle after a pop
//   buf_empty  in   1       FIFO empty flag
//   rd_en      out  1       FIFO pop request (combinational)
//   m_data     out  DATA_W  stream data (head of the output buffer)
//   m_valid    out  1       stream data valid
//   m_ready    in   1       consumer accepts m_data this cycle
//   flush      in   1       discard all buffered and in-flight words
//   pop_count  out  CNT_W   pops issued since reset, wraps modulo 2^CNT_W
//   busy       out  1       buffer holds a word or a pop is in flight
//
// Stream handshake: a word moves from this block to the consumer at a rising
// edge where m_valid and m_ready are both 1. m_valid never depends on m_ready;
// once raised, m_valid and m_data hold until that transfer (or a flush/reset).
// -----------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] buf_out,
    input  logic              buf_empty,
    output logic              rd_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    input  logic              flush,
    output logic [CNT_W-1:0]  pop_count,
    output logic              busy
);

    // Control state: occupancy of the 2-entry output buffer plus a flag for a
    // pop whose data arrives on buf_out in the current cycle.
    typedef struct packed {
        logic [1:0] occ;
        logic       inflight;
    } rd_state_t;

    rd_state_t         st_q;
    rd_state_t         st_d;
    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] head_d;
    logic [DATA_W-1:0] tail_q;
    logic [DATA_W-1:0] tail_d;
    logic [CNT_W-1:0]  pop_cnt_q;
    logic [CNT_W-1:0]  pop_cnt_d;

    logic              xfer;
    logic [2:0]        outstanding;
    logic              credit_ok;

    // Handshake and credit. Words owed to the consumer are the buffered ones
    // plus the one in flight; a word leaving this cycle frees its slot in time
    // for a new pop, which is what allows back-to-back delivery.
    assign xfer        = (st_q.occ != 2'd0) && m_ready;
    assign outstanding = {1'b0, st_q.occ} + {2'b00, st_q.inflight} - {2'b00, xfer};
    assign credit_ok   = (outstanding < 3'd2);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            pop_cnt_q <= '0;
        end else begin
            st_q      <= st_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            pop_cnt_q <= pop_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        st_d      = st_q;
        head_d    = head_q;
        tail_d    = tail_q;
        pop_cnt_d = pop_cnt_q + CNT_W'(rd_en);

        if (flush) begin
            // Drop everything owed, including the word on buf_out this cycle.
            // Buffer contents are left as-is; m_valid=0 makes them meaningless.
            st_d.occ      = 2'd0;
            st_d.inflight = 1'b0;
        end else begin
            st_d.inflight = rd_en;
            case ({st_q.inflight, xfer})
                2'b01: begin
                    // Head leaves; the second entry (if any) moves up.
                    if (st_q.occ == 2'd2) begin
                        head_d = tail_q;
                    end
                    st_d.occ = st_q.occ - 2'd1;
                end
                2'b10: begin
                    // Arriving word appends behind whatever is buffered.
                    if (st_q.occ == 2'd0) begin
                        head_d = buf_out;
                    end else begin
                        tail_d = buf_out;
                    end
                    st_d.occ = st_q.occ + 2'd1;
                end
                2'b11: begin
                    // Head leaves and a word arrives: occupancy unchanged,
                    // arriving word goes to the back to keep FIFO order.
                    if (st_q.occ == 2'd1) begin
                        head_d = buf_out;
                    end else begin
                        head_d = tail_q;
                        tail_d = buf_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        m_valid   = (st_q.occ != 2'd0);
        m_data    = head_q;
        // rst_n gating keeps the FIFO from seeing a pop while both are held
        // in reset.
        rd_en     = rst_n && !buf_empty && !flush && credit_ok;
        busy      = (st_q.occ != 2'd0) || st_q.inflight;
        pop_count = pop_cnt_q;
    end

    // A word landing while both slots are full and none leaves would be lost;
    // the credit rule on rd_en must make this unreachable.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(st_q.inflight && !xfer && (st_q.occ == 2'd2)));

    a_occ_range : assert property (@(posedge clk) disable iff (!rst_n)
        st_q.occ != 2'd3);

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] buf_out;
  logic              buf_empty;
  logic              m_ready;
  logic              flush;
  logic              rd_en;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic [CNT_W-1:0]  pop_count;
  logic              busy;

  logic              rd_en4;
  logic [DATA_W-1:0] m_data4;
  logic              m_valid4;
  logic [3:0]        pop_count4;
  logic              busy4;

  fifo_stream_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .buf_out   (buf_out),
    .buf_empty (buf_empty),
    .rd_en     (rd_en),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .flush     (flush),
    .pop_count (pop_count),
    .busy      (busy)
  );

  // narrow counter instance for the wrap case; shares every input
  fifo_stream_reader #(.DATA_W(DATA_W), .CNT_W(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .buf_out   (buf_out),
    .buf_empty (buf_empty),
    .rd_en     (rd_en4),
    .m_data    (m_data4),
    .m_valid   (m_valid4),
    .m_ready   (m_ready),
    .flush     (flush),
    .pop_count (pop_count4),
    .busy      (busy4)
  );

  // counters
  int n_pass;
  int n_total;

  // FIFO contents, words owed to the consumer, and the cycle each becomes visible
  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int                avail_q[$];
  logic [DATA_W-1:0] got_q[$];
  int                got_cyc_q[$];
  logic [DATA_W-1:0] wr_log[$];

  int          cyc;
  int unsigned pops_model;
  logic        drv_ready;
  logic        drv_flush;
  logic        pend_valid;
  logic [DATA_W-1:0] pend_word;

  // last sampled outputs
  logic              s_rd_en;
  logic              s_m_valid;
  logic              s_busy;
  logic [DATA_W-1:0] s_m_data;
  logic [CNT_W-1:0]  s_pop_count;
  logic [3:0]        s_pop_count4;

  // per-test scratch
  logic [6:0]        t1_rd;
  logic [6:0]        t1_v;
  logic [DATA_W-1:0] t1_d[7];
  logic [CNT_W-1:0]  t1_pc;
  int                nrd;
  int                nvalid;
  int                nbusy;
  int                nbad;
  int                n_wr;
  int                budget;
  logic [DATA_W-1:0] w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    fifo_q.delete();
    exp_q.delete();
    avail_q.delete();
    pops_model = 0;
    pend_valid = 1'b0;
    buf_out    = '0;
  endtask

  // One clock cycle: drive, compare against the model, advance model and FIFO.
  task automatic step();
    logic e_valid;
    logic e_rd;
    logic xfer_m;
    logic [DATA_W-1:0] word;
    @(negedge clk);
    m_ready   = drv_ready;
    flush     = drv_flush;
    buf_empty = (fifo_q.size() == 0);
    #1;
    e_valid = (exp_q.size() != 0) && (avail_q[0] <= cyc);
    xfer_m  = e_valid && drv_ready;
    e_rd    = !buf_empty && !drv_flush && ((exp_q.size() - (xfer_m ? 1 : 0)) < 2);

    chk("m_valid", m_valid, e_valid);
    if (e_valid) chk("m_data", m_data, exp_q[0]);
    chk("rd_en", rd_en, e_rd);
    chk("rd_en_cnt4", rd_en4, e_rd);
    chk("busy", busy, exp_q.size() != 0);
    chk("pop_count", pop_count, pops_model % 65536);
    chk("pop_count4", pop_count4, pops_model % 16);

    s_rd_en      = rd_en;
    s_m_valid    = m_valid;
    s_busy       = busy;
    s_m_data     = m_data;
    s_pop_count  = pop_count;
    s_pop_count4 = pop_count4;
    if (m_valid && m_ready) begin
      got_q.push_back(m_data);
      got_cyc_q.push_back(cyc);
    end

    if (e_rd) pops_model++;
    word = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    if (drv_flush) begin
      exp_q.delete();
      avail_q.delete();
    end else begin
      if (xfer_m) begin
        void'(exp_q.pop_front());
        void'(avail_q.pop_front());
      end
      if (e_rd) begin
        exp_q.push_back(word);
        avail_q.push_back(cyc + 2);
      end
    end

    pend_valid = 1'b0;
    if (rd_en && fifo_q.size() != 0) begin
      pend_valid = 1'b1;
      pend_word  = fifo_q.pop_front();
    end
    @(posedge clk);
    #1;
    if (pend_valid) buf_out = pend_word;
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_total = 0; cyc = 0; pops_model = 0;
    pend_valid = 1'b0; pend_word = '0;
    drv_ready = 1'b1; drv_flush = 1'b0;
    rst_n = 1'b0; buf_out = '0; buf_empty = 1'b0; m_ready = 1'b1; flush = 1'b0;

    // reset state; buf_empty=0 shows rd_en is held low during reset
    repeat (3) @(posedge clk);
    #2;
    chk("reset_m_valid", m_valid, 0);
    chk("reset_m_data", m_data, 0);
    chk("reset_pop_count", pop_count, 0);
    chk("reset_rd_en_forced", rd_en, 0);
    chk("reset_busy", busy, 0);
    buf_empty = 1'b1;
    #1 rst_n = 1'b1;

    // 1: three preloaded words, consumer always ready
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
    drv_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      t1_rd[i] = s_rd_en;
      t1_v[i]  = s_m_valid;
      t1_d[i]  = s_m_data;
      t1_pc    = s_pop_count;
    end
    chk("t1_rd_en_cycles", t1_rd, 7'b0000111);
    chk("t1_m_valid_cycles", t1_v, 7'b0011100);
    chk("t1_word0", t1_d[2], 8'h11);
    chk("t1_word1", t1_d[3], 8'h22);
    chk("t1_word2", t1_d[4], 8'h33);
    chk("t1_pop_count", t1_pc, 3);

    // 2: five queued words with the consumer stalled, then released
    for (int i = 0; i < 5; i++) fifo_q.push_back(8'hA0 + 8'(i));
    drv_ready = 1'b0;
    nrd = 0; nvalid = 0; nbad = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (s_rd_en) nrd++;
      if (s_m_valid) begin
        nvalid++;
        if (s_m_data !== 8'hA0) nbad++;
      end
    end
    chk("t2_stalled_pops", nrd, 2);
    chk("t2_valid_cycles", nvalid, 6);
    chk("t2_head_stable", nbad, 0);
    got_q.delete(); got_cyc_q.delete();
    drv_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("t2_delivered", got_q.size(), 5);
    nbad = 0;
    for (int i = 0; i < got_q.size() && i < 5; i++)
      if (got_q[i] !== 8'hA0 + 8'(i)) nbad++;
    chk("t2_order", nbad, 0);
    if (got_cyc_q.size() >= 5) chk("t2_no_gaps", got_cyc_q[4] - got_cyc_q[0], 4);

    // 3: empty FIFO for 20 cycles
    nrd = 0; nvalid = 0; nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_rd_en) nrd++;
      if (s_m_valid) nvalid++;
      if (s_busy) nbusy++;
    end
    chk("t3_no_pops", nrd, 0);
    chk("t3_no_valid", nvalid, 0);
    chk("t3_not_busy", nbusy, 0);

    // 4: flush with a full buffer
    for (int i = 1; i <= 6; i++) fifo_q.push_back(8'hB0 + 8'(i));
    drv_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    drv_flush = 1'b1;
    step();
    chk("t4_no_pop_in_flush", s_rd_en, 0);
    drv_flush = 1'b0;
    step();
    chk("t4_valid_dropped", s_m_valid, 0);
    got_q.delete(); got_cyc_q.delete();
    drv_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("t4_delivered", got_q.size(), 4);
    if (got_q.size() > 0) chk("t4_first_after_flush", got_q[0], 8'hB3);

    // 5: asynchronous reset mid-stream
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'hC0 + 8'(i));
    for (int i = 0; i < 4; i++) step();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_m_valid", m_valid, 0);
    chk("t5_pop_count", pop_count, 0);
    chk("t5_pop_count4", pop_count4, 0);
    chk("t5_rd_en", rd_en, 0);
    chk("t5_busy", busy, 0);
    model_reset();
    buf_empty = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // 6a: 17 pops from reset; narrow counter wraps to 1
    got_q.delete(); got_cyc_q.delete();
    for (int i = 0; i < 17; i++) fifo_q.push_back(8'hD0 + 8'(i));
    for (int i = 0; i < 22; i++) step();
    chk("t6_pop_count4_wrap", s_pop_count4, 1);
    chk("t6_pop_count", s_pop_count, 17);
    chk("t6_delivered", got_q.size(), 17);
    if (got_q.size() > 0) chk("t5_no_stale_word", got_q[0], 8'hD0);

    // 6b: 1000 random words, random consumer stalls
    got_q.delete(); got_cyc_q.delete(); wr_log.delete();
    n_wr = 0; budget = 0;
    while (got_q.size() < 1000 && budget < 20000) begin
      if (n_wr < 1000 && $urandom_range(0, 3) != 0) begin
        w = DATA_W'($urandom_range(0, 255));
        fifo_q.push_back(w);
        wr_log.push_back(w);
        n_wr++;
      end
      drv_ready = ($urandom_range(0, 3) != 0);
      step();
      budget++;
    end
    chk("t6_random_delivered", got_q.size(), 1000);
    nbad = 0;
    for (int i = 0; i < got_q.size() && i < wr_log.size(); i++)
      if (got_q[i] !== wr_log[i]) nbad++;
    chk("t6_random_order", nbad, 0);

    // random flushes against the model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) != 0) fifo_q.push_back(DATA_W'($urandom_range(0, 255)));
      drv_ready = ($urandom_range(0, 2) != 0);
      drv_flush = ($urandom_range(0, 19) == 0);
      step();
    end
    drv_flush = 1'b0;
    drv_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
